// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults and op encodings
// for the pipelined add/subtract unit.
package adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  localparam logic ADD_OP = 1'b0;
  localparam logic SUB_OP = 1'b1;

endpackage

// File: rtl/adder_stage.sv
// adder_stage: one registered CW-bit slice of the
// carry chain with valid bit and hold enable.
module adder_stage
  import adder_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in_valid,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic          valid,
  output logic [CW-1:0] sum,
  output logic          cout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (en) begin
      valid <= in_valid;
      {cout, sum} <= {1'b0, a}
                   + {1'b0, b}
                   + {{CW{1'b0}}, cin};
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep chunked add/sub with
// valid/ready backpressure; flags under ADDER_FLAGS_EN.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = WIDTH / STAGES;
  localparam logic [WIDTH-1:0] CMASK =
    WIDTH'({CW{1'b1}});

  logic              en;
  logic [STAGES:0]   vld;
  logic [STAGES:0]   c;
  logic [WIDTH-1:0]  w  [STAGES];
  logic [WIDTH-1:0]  b  [STAGES];
  logic [WIDTH-1:0]  fw [STAGES];
  logic [CW-1:0]     s  [STAGES];
  logic [WIDTH-1:0]  unused_b;

  assign out_valid = vld[STAGES];
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;

  assign vld[0] = in_valid;
  assign w[0]   = op1;
  assign b[0]   = (sub == ADD_OP) ? op2 : ~op2;
  assign c[0]   = (sub == SUB_OP);

  // w[k] holds finished result chunks below k
  // and still-pending op1 chunks from k upward.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] fw_q;

    adder_stage #(
      .CW(CW)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .in_valid (vld[k]),
      .a        (w[k][k*CW +: CW]),
      .b        (b[k][k*CW +: CW]),
      .cin      (c[k]),
      .valid    (vld[k+1]),
      .sum      (s[k]),
      .cout     (c[k+1])
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        fw_q <= '0;
      end else if (en) begin
        fw_q <= w[k] & ~(CMASK << (k*CW));
      end
    end

    assign fw[k] = fw_q;

    if (k < STAGES-1) begin : g_fwd
      logic [WIDTH-1:0] fb_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          fb_q <= '0;
        end else if (en) begin
          fb_q <= b[k];
        end
      end

      assign b[k+1] = fb_q;
      assign w[k+1] = fw[k]
                    | (WIDTH'(s[k]) << (k*CW));
    end
  end

  assign res = fw[STAGES-1]
             | (WIDTH'(s[STAGES-1])
                << ((STAGES-1)*CW));

  assign unused_b = b[STAGES-1];

`ifdef ADDER_FLAGS_EN
  logic a_msb_q;
  logic b_msb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (en) begin
      a_msb_q <= w[STAGES-1][WIDTH-1];
      b_msb_q <= b[STAGES-1][WIDTH-1];
    end
  end

  assign carry    = c[STAGES];
  assign overflow = out_valid
                  && (a_msb_q == b_msb_q)
                  && (res[WIDTH-1] != a_msb_q);
  assign zero     = out_valid && (res == '0);
`else
  logic unused_c;

  assign unused_c = c[STAGES];
  assign carry    = 1'b0;
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

endmodule
